seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with latched BCD shadow and leading-zero blanking.
// Optional overflow blink of the digit enables is built when SEG_OVER_BLINK_EN is defined.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned MIN_DIGITS  = 1,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic                      clk_50M,
  input  logic                      rst_n,
  input  logic                      latch,
  input  logic [4*DIGITS-1:0]       data,
  input  logic                      dp_en,
  input  logic [$clog2(DIGITS)-1:0] dp_pos,
  input  logic                      over,
  output logic [6:0]                seg,
  output logic                      dp_out,
  output logic [DIGITS-1:0]         an,
  output logic                      over_led
);

  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CntLast = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IdxLast = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] KeepMask = DIGITS'((64'd1 << MIN_DIGITS) - 64'd1);
  localparam logic [DIGITS-1:0] BlankRst = ~KeepMask;

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] code;
    case (bcd)
      4'd0:    code = 7'b0000001;
      4'd1:    code = 7'b1001111;
      4'd2:    code = 7'b0010010;
      4'd3:    code = 7'b0000110;
      4'd4:    code = 7'b1001100;
      4'd5:    code = 7'b0100100;
      4'd6:    code = 7'b0100000;
      4'd7:    code = 7'b0001111;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0000100;
      default: code = 7'b1111111;
    endcase
    return code;
  endfunction

  // Latch synchroniser and rising-edge detect
  logic latch_meta_q, latch_s1_q, latch_s2_q;
  logic rise;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      latch_meta_q <= 1'b0;
      latch_s1_q   <= 1'b0;
      latch_s2_q   <= 1'b0;
    end else begin
      latch_meta_q <= latch;
      latch_s1_q   <= latch_meta_q;
      latch_s2_q   <= latch_s1_q;
    end
  end

  assign rise = latch_s1_q & ~latch_s2_q;

  // Shadow copy of the display inputs
  logic [3:0]    sh_digit_q [DIGITS];
  logic          sh_dp_en_q;
  logic [IW-1:0] sh_dp_pos_q;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        sh_digit_q[i] <= 4'd0;
      end
      sh_dp_en_q  <= 1'b0;
      sh_dp_pos_q <= '0;
    end else if (rise) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        sh_digit_q[i] <= data[4*i +: 4];
      end
      sh_dp_en_q  <= dp_en;
      sh_dp_pos_q <= dp_pos;
    end
  end

  // Leading-zero blank mask, scanned from the most significant digit down
  logic [DIGITS-1:0] blank_d, blank_q;
  logic              zero_run;
  logic              dp_valid;

  always_comb begin
    blank_d  = '0;
    zero_run = 1'b1;
    dp_valid = sh_dp_en_q && (32'(sh_dp_pos_q) < DIGITS);
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run   = zero_run && (sh_digit_q[i] == 4'd0);
      blank_d[i] = (i >= int'(MIN_DIGITS)) && zero_run &&
                   !(dp_valid && (i <= int'(sh_dp_pos_q)));
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= BlankRst;
    end else begin
      blank_q <= blank_d;
    end
  end

  // Digit-slot prescaler; tick is registered so it lands one edge after terminal count
  logic [CW-1:0] cnt_q;
  logic          tick_q;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == CntLast);
      if (cnt_q == CntLast) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Overflow blink gating of the digit enables
  logic blank_all;

`ifdef SEG_OVER_BLINK_EN
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_TICKS - 1);

  logic [BW-1:0] blink_cnt_q;
  logic          phase_q;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (!over) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (tick_q) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign blank_all = over & phase_q;
`else
  assign blank_all = 1'b0;
`endif

  // Output register: loaded for the current idx on each tick, then idx advances
  logic [IW-1:0]     idx_q;
  logic [DIGITS-1:0] one_hot;
  logic [DIGITS-1:0] an_d, an_q;
  logic [6:0]        seg_d, seg_q;
  logic              dp_d, dp_q;

  assign one_hot = DIGITS'(1) << idx_q;

  always_comb begin
    an_d  = blank_all ? '1 : ~one_hot;
    seg_d = blank_q[idx_q] ? 7'h7F : seg_decode(sh_digit_q[idx_q]);
    dp_d  = ~(sh_dp_en_q & (sh_dp_pos_q == idx_q));
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else if (tick_q) begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      over_led <= 1'b1;
    end else begin
      over_led <= ~over;
    end
  end

  assign an     = an_q;
  assign seg    = seg_q;
  assign dp_out = dp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (DIGITS=8, SCAN_DIV=4, MIN_DIGITS=1).
module tb_seg_scan_ctrl;

  localparam int unsigned DIGITS = 8;

  logic        clk_50M = 1'b0;
  logic        rst_n;
  logic        latch;
  logic [31:0] data;
  logic        dp_en;
  logic [2:0]  dp_pos;
  logic        over;
  logic [6:0]  seg;
  logic        dp_out;
  logic [7:0]  an;
  logic        over_led;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  seg_scan_ctrl #(
    .DIGITS     (DIGITS),
    .SCAN_DIV   (4),
    .MIN_DIGITS (1),
    .BLINK_TICKS(2)
  ) dut (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .latch   (latch),
    .data    (data),
    .dp_en   (dp_en),
    .dp_pos  (dp_pos),
    .over    (over),
    .seg     (seg),
    .dp_out  (dp_out),
    .an      (an),
    .over_led(over_led)
  );

  always #5 clk_50M = ~clk_50M;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Returns at the first negedge where an shows the wanted value
  task automatic wait_an(input logic [7:0] want, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 80 && !ok; c++) begin
      @(negedge clk_50M);
      if (an === want) ok = 1'b1;
    end
  endtask

  task automatic pulse_latch(input logic [31:0] d, input logic e, input logic [2:0] p);
    @(negedge clk_50M);
    data = d; dp_en = e; dp_pos = p; latch = 1'b1;
    repeat (4) @(negedge clk_50M);
    latch = 1'b0;
    repeat (40) @(negedge clk_50M);
  endtask

  task automatic test_reset;
    bit ok;
    wait_an(8'hFB, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_wait_fb: an=%h required fb", an); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h required ff", an); end
    checks++;
    if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h required 7f", seg); end
    checks++;
    if (dp_out !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b required 1", dp_out); end
    checks++;
    if (over_led !== 1'b1) begin
      errors++; $display("FAIL reset_over_led: got %b required 1", over_led);
    end
    @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_50M);
    checks++;
    if (an !== 8'hFF) begin errors++; $display("FAIL release_an_4: got %h required ff", an); end
    @(negedge clk_50M);
    checks++;
    if (an !== 8'hFE) begin errors++; $display("FAIL release_an_5: got %h required fe", an); end
    checks++;
    if (seg !== 7'b0000001) begin
      errors++; $display("FAIL release_seg: got %b required 0000001", seg);
    end
  endtask

  task automatic test_digits;
    bit ok;
    int dig [8] = '{5, 4, 3, 2, 1, 0, 0, 0};
    logic [6:0] exp_seg;
    pulse_latch(32'h0001_2345, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      wait_an(~(8'd1 << i), ok);
      exp_seg = (i < 5) ? seg_tab[dig[i]] : 7'h7F;
      checks++;
      if (!ok || seg !== exp_seg) begin
        errors++; $display("FAIL digits_seg[%0d]: an=%h seg=%b required %b", i, an, seg, exp_seg);
      end
      checks++;
      if (dp_out !== 1'b1) begin
        errors++; $display("FAIL digits_dp[%0d]: got %b required 1", i, dp_out);
      end
    end
  endtask

  task automatic test_dp;
    bit ok;
    logic [6:0] exp_seg;
    logic       exp_dp;
    pulse_latch(32'h0, 1'b1, 3'd2);
    for (int i = 0; i < 8; i++) begin
      wait_an(~(8'd1 << i), ok);
      exp_seg = (i <= 2) ? 7'b0000001 : 7'h7F;
      exp_dp  = (i == 2) ? 1'b0 : 1'b1;
      checks++;
      if (!ok || seg !== exp_seg) begin
        errors++; $display("FAIL dp_seg[%0d]: an=%h seg=%b required %b", i, an, seg, exp_seg);
      end
      checks++;
      if (dp_out !== exp_dp) begin
        errors++; $display("FAIL dp_out[%0d]: got %b required %b", i, dp_out, exp_dp);
      end
    end
  endtask

  task automatic test_latch_hold;
    bit ok;
    @(negedge clk_50M);
    data = 32'h1; dp_en = 1'b0; dp_pos = 3'd0; latch = 1'b1;
    repeat (10) @(negedge clk_50M);
    data = 32'h2;
    repeat (10) @(negedge clk_50M);
    latch = 1'b0;
    repeat (40) @(negedge clk_50M);
    wait_an(8'hFE, ok);
    checks++;
    if (!ok || seg !== 7'b1001111) begin
      errors++; $display("FAIL hold_digit0: seg=%b required 1001111", seg);
    end
    wait_an(8'hFD, ok);
    checks++;
    if (!ok || seg !== 7'h7F) begin
      errors++; $display("FAIL hold_digit1: seg=%b required 1111111", seg);
    end
    pulse_latch(32'h2, 1'b0, 3'd0);
    wait_an(8'hFE, ok);
    checks++;
    if (!ok || seg !== 7'b0010010) begin
      errors++; $display("FAIL relatch_digit0: seg=%b required 0010010", seg);
    end
  endtask

  // Shadow load lands on the same edge that loads the digit-1 slot
  task automatic test_latch_on_tick;
    bit ok;
    wait_an(8'hFE, ok);
    @(negedge clk_50M);
    data = 32'h70; latch = 1'b1;
    repeat (3) @(negedge clk_50M);
    checks++;
    if (!ok || an !== 8'hFD) begin
      errors++; $display("FAIL tick_latch_an: got %h required fd", an);
    end
    checks++;
    if (seg !== 7'h7F) begin
      errors++; $display("FAIL tick_latch_old: seg=%b required 1111111", seg);
    end
    latch = 1'b0;
    wait_an(8'hFE, ok);
    checks++;
    if (!ok || seg !== 7'b0000001) begin
      errors++; $display("FAIL tick_latch_d0: seg=%b required 0000001", seg);
    end
    wait_an(8'hFD, ok);
    checks++;
    if (!ok || seg !== 7'b0001111) begin
      errors++; $display("FAIL tick_latch_new: seg=%b required 0001111", seg);
    end
  endtask

  task automatic test_free_run;
    bit ok, ok2;
    logic [7:0] exp_an;
    wait_an(8'h7F, ok);
    wait_an(8'hFE, ok2);
    checks++;
    if (!ok || !ok2) begin errors++; $display("FAIL free_sync: an=%h required fe", an); end
    for (int s = 0; s < 16; s++) begin
      exp_an = ~(8'd1 << (s % 8));
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (an !== exp_an) begin
          errors++; $display("FAIL free_an[%0d.%0d]: got %h required %h", s, c, an, exp_an);
        end
        @(negedge clk_50M);
      end
    end
  endtask

  task automatic test_over;
    bit ok;
    logic [7:0] exp_an [7];
`ifdef SEG_OVER_BLINK_EN
    exp_an = '{8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hDF, 8'hBF, 8'hFF};
`else
    exp_an = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
`endif
    wait_an(8'hFE, ok);
    over = 1'b1;
    @(negedge clk_50M);
    checks++;
    if (!ok || over_led !== 1'b0) begin
      errors++; $display("FAIL over_led_on: got %b required 0", over_led);
    end
    repeat (3) @(negedge clk_50M);
    for (int s = 0; s < 7; s++) begin
      checks++;
      if (an !== exp_an[s]) begin
        errors++; $display("FAIL over_an[%0d]: got %h required %h", s, an, exp_an[s]);
      end
      if (s < 6) repeat (4) @(negedge clk_50M);
    end
    over = 1'b0;
    @(negedge clk_50M);
    checks++;
    if (over_led !== 1'b1) begin
      errors++; $display("FAIL over_led_off: got %b required 1", over_led);
    end
    repeat (3) @(negedge clk_50M);
    checks++;
    if (an !== 8'hFE) begin errors++; $display("FAIL over_drop_an0: got %h required fe", an); end
    repeat (4) @(negedge clk_50M);
    checks++;
    if (an !== 8'hFD) begin errors++; $display("FAIL over_drop_an1: got %h required fd", an); end
  endtask

  initial begin
    rst_n  = 1'b0;
    latch  = 1'b0;
    data   = 32'h0;
    dp_en  = 1'b0;
    dp_pos = 3'd0;
    over   = 1'b0;
    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    test_reset;
    test_digits;
    test_dp;
    test_latch_hold;
    test_latch_on_tick;
    test_free_run;
    test_over;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
